// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared types and constants for the cartridge loader.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  // Loader sequencer states
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_HOLD = 2'd2
  } ld_state_t;

  // Value presented on the read port while the core is held in reset
  localparam logic [7:0] ROM_FILL = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/rca_rom_bank.sv
`default_nettype none
// ============================================================================
// Module      : rca_rom_bank
// Description : Simple dual-port byte RAM, one write port and one read port
//               with a registered output. No reset on the array or output.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_rom_bank #(
  parameter int AW = 13
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/rca_cart_loader.sv
`default_nettype none
// ============================================================================
// Module      : rca_cart_loader
// Description : Cartridge loader between the ioctl download stream and the
//               console core. Captures images into SLOTS ROM banks, tracks
//               size / mirror mask / overflow per slot, holds the core in
//               reset during and RESET_HOLD cycles after a download, and
//               serves one registered read port.
//               Optional build macro RCA_CART_CHECKSUM_EN adds o_cart_sum,
//               a 16-bit running sum of accepted bytes of the latest load.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_cart_loader
  import rca_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int SLOTS      = 2,
  parameter int INDEX_BASE = 1,
  parameter int RESET_HOLD = 16,
  localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ioctl_download,
  input  logic [7:0]        i_ioctl_index,
  input  logic              i_ioctl_wr,
  input  logic [24:0]       i_ioctl_addr,
  input  logic [7:0]        i_ioctl_dout,
  input  logic [SLOT_W-1:0] i_rd_slot,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_sys_reset,
  output logic [SLOTS-1:0]  o_cart_loaded,
  output logic [SLOTS-1:0]  o_cart_overflow,
  output logic [ADDR_W:0]   o_cart_size
`ifdef RCA_CART_CHECKSUM_EN
  ,
  output logic [15:0]       o_cart_sum
`endif
);

  localparam int              HOLD_W     = $clog2(RESET_HOLD + 1);
  localparam int              MEM_AW     = SLOT_W + ADDR_W;
  localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] c_FULL     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HOLD_W-1:0] c_HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0] c_HOLD_ONE  = HOLD_W'(1);

  // Smallest 2^k-1 covering byte offsets 0..size-1; empty image mirrors nothing
  function automatic logic [ADDR_W-1:0] size_mask(input logic [ADDR_W:0] size);
    logic [ADDR_W-1:0] m;
    m = ADDR_W'(size - c_ONE);
    for (int i = 1; i < ADDR_W; i++) begin
      m = m | (m >> i);
    end
    return (size == '0) ? '1 : m;
  endfunction

  ld_state_t           r_state;
  ld_state_t           w_state_next;
  logic                w_start;
  logic                w_done;
  logic [5:0]          w_idx_off;
  logic                w_idx_ok;
  logic [SLOT_W-1:0]   r_slot;
  logic [ADDR_W:0]     r_size_cnt;
  logic [ADDR_W:0]     w_size_next;
  logic [ADDR_W:0]     w_addr_p1;
  logic                w_in_range;
  logic                w_wr_acc;
  logic                w_wr_ovf;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [SLOTS-1:0]    r_loaded;
  logic [SLOTS-1:0]    r_overflow;
  logic [ADDR_W:0]     r_cart_size;
  logic [ADDR_W-1:0]   r_mask [SLOTS];
  logic                r_fill;
  logic [ADDR_W-1:0]   w_rd_mask;
  logic [7:0]          w_bank_q;
  logic                w_unused_idx;

  // Index bits 7:6 carry the file-type extension and do not select a slot
  assign w_unused_idx = &{1'b0, i_ioctl_index[7:6]};

  assign w_idx_off  = i_ioctl_index[5:0] - 6'(INDEX_BASE);
  assign w_idx_ok   = (int'({26'd0, w_idx_off}) < SLOTS);
  assign w_in_range = (i_ioctl_addr[24:ADDR_W] == '0);
  assign w_wr_acc   = (r_state == LD_LOAD) && i_ioctl_wr && w_in_range;
  assign w_wr_ovf   = (r_state == LD_LOAD) && i_ioctl_wr && !w_in_range;
  assign w_addr_p1  = {1'b0, i_ioctl_addr[ADDR_W-1:0]} + c_ONE;

  // State register; reset parks the sequencer in HOLD so the core stays reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= LD_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and load start/finish strobes
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (i_ioctl_download && w_idx_ok) begin
          w_state_next = LD_LOAD;
          w_start      = 1'b1;
        end
      end
      LD_LOAD: begin
        if (!i_ioctl_download) begin
          w_state_next = LD_HOLD;
          w_done       = 1'b1;
        end
      end
      LD_HOLD: begin
        if (i_ioctl_download && w_idx_ok) begin
          w_state_next = LD_LOAD;
          w_start      = 1'b1;
        end else if (r_hold_cnt <= c_HOLD_ONE) begin
          w_state_next = LD_IDLE;
        end
      end
      default: begin
        w_state_next = LD_HOLD;
      end
    endcase
  end

  // Running image size: highest accepted address + 1, pinned full on overflow
  always_comb begin
    w_size_next = r_size_cnt;
    if (w_wr_acc && (w_addr_p1 > r_size_cnt)) begin
      w_size_next = w_addr_p1;
    end else if (w_wr_ovf) begin
      w_size_next = c_FULL;
    end
  end

  // Post-download hold counter, reloaded whenever a load finishes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold_cnt <= c_HOLD_INIT;
    end else if (w_done) begin
      r_hold_cnt <= c_HOLD_INIT;
    end else if ((r_state == LD_HOLD) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
    end
  end

  // Per-slot status, target slot and size tracking
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot      <= '0;
      r_size_cnt  <= '0;
      r_loaded    <= '0;
      r_overflow  <= '0;
      r_cart_size <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_mask[s] <= '1;
      end
    end else if (w_start) begin
      r_slot                            <= w_idx_off[SLOT_W-1:0];
      r_size_cnt                        <= '0;
      r_loaded[w_idx_off[SLOT_W-1:0]]   <= 1'b0;
      r_overflow[w_idx_off[SLOT_W-1:0]] <= 1'b0;
    end else if (r_state == LD_LOAD) begin
      r_size_cnt <= w_size_next;
      if (w_wr_ovf) begin
        r_overflow[r_slot] <= 1'b1;
      end
      if (w_done) begin
        r_cart_size      <= w_size_next;
        r_loaded[r_slot] <= (w_size_next != '0);
        r_mask[r_slot]   <= size_mask(w_size_next);
      end
    end
  end

  // Read data is forced to the fill byte for any read issued outside IDLE
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill <= 1'b1;
    end else begin
      r_fill <= (r_state != LD_IDLE);
    end
  end

  assign w_rd_mask = (int'({{(32-SLOT_W){1'b0}}, i_rd_slot}) < SLOTS) ? r_mask[i_rd_slot] : '1;

  rca_rom_bank #(
    .AW (MEM_AW)
  ) u_rom (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc),
    .i_waddr ({r_slot, i_ioctl_addr[ADDR_W-1:0]}),
    .i_wdata (i_ioctl_dout),
    .i_raddr ({i_rd_slot, i_rd_addr & w_rd_mask}),
    .o_rdata (w_bank_q)
  );

  assign o_rd_data       = r_fill ? ROM_FILL : w_bank_q;
  assign o_sys_reset     = i_reset | (r_state != LD_IDLE);
  assign o_cart_loaded   = r_loaded;
  assign o_cart_overflow = r_overflow;
  assign o_cart_size     = r_cart_size;

`ifdef RCA_CART_CHECKSUM_EN
  logic [15:0] r_sum;

  // Wrap-around sum of bytes actually stored by the current/latest load
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_wr_acc) begin
      r_sum <= r_sum + {8'h00, i_ioctl_dout};
    end
  end

  assign o_cart_sum = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rca_cart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_cart_loader
// Description : Self-checking bench for rca_cart_loader with a behavioural
//               model of slot contents, sizes, masks and status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_cart_loader;

  localparam int ADDR_W     = 12;
  localparam int SLOTS      = 2;
  localparam int INDEX_BASE = 1;
  localparam int RESET_HOLD = 16;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_download = 1'b0;
  logic [7:0]        i_index = '0;
  logic              i_wr = 1'b0;
  logic [24:0]       i_addr = '0;
  logic [7:0]        i_dout = '0;
  logic [0:0]        i_rd_slot = '0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic [7:0]        o_rd_data;
  logic              o_sys_reset;
  logic [SLOTS-1:0]  o_cart_loaded;
  logic [SLOTS-1:0]  o_cart_overflow;
  logic [ADDR_W:0]   o_cart_size;
`ifdef RCA_CART_CHECKSUM_EN
  logic [15:0]       o_cart_sum;
`endif

  always #5 clk = ~clk;

  rca_cart_loader #(
    .ADDR_W     (ADDR_W),
    .SLOTS      (SLOTS),
    .INDEX_BASE (INDEX_BASE),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_ioctl_download (i_download),
    .i_ioctl_index    (i_index),
    .i_ioctl_wr       (i_wr),
    .i_ioctl_addr     (i_addr),
    .i_ioctl_dout     (i_dout),
    .i_rd_slot        (i_rd_slot),
    .i_rd_addr        (i_rd_addr),
    .o_rd_data        (o_rd_data),
    .o_sys_reset      (o_sys_reset),
    .o_cart_loaded    (o_cart_loaded),
    .o_cart_overflow  (o_cart_overflow),
    .o_cart_size      (o_cart_size)
`ifdef RCA_CART_CHECKSUM_EN
    ,
    .o_cart_sum       (o_cart_sum)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: -1 marks a byte never written
  int           m_mem [SLOTS][DEPTH];
  bit [SLOTS-1:0] m_loaded;
  bit [SLOTS-1:0] m_ovf;
  int           m_size;
  int           m_mask [SLOTS];
  int           m_sum;
  int           q_addr [$];
  int           q_data [$];

  function automatic int mask_of(input int sz);
    int p;
    if (sz == 0) return DEPTH - 1;
    p = 1;
    while (p < sz) p = p * 2;
    return p - 1;
  endfunction

  task automatic model_reset();
    m_loaded = '0;
    m_ovf    = '0;
    m_size   = 0;
    m_sum    = 0;
    for (int s = 0; s < SLOTS; s++) m_mask[s] = DEPTH - 1;
  endtask

  task automatic check_status();
    n_cmp++;
    if (o_cart_loaded !== m_loaded) begin
      n_bad++;
      $display("FAIL cart_loaded: got %b want %b", o_cart_loaded, m_loaded);
    end
    n_cmp++;
    if (o_cart_overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL cart_overflow: got %b want %b", o_cart_overflow, m_ovf);
    end
    n_cmp++;
    if (o_cart_size !== (ADDR_W+1)'(m_size)) begin
      n_bad++;
      $display("FAIL cart_size: got %0d want %0d", o_cart_size, m_size);
    end
`ifdef RCA_CART_CHECKSUM_EN
    n_cmp++;
    if (o_cart_sum !== 16'(m_sum)) begin
      n_bad++;
      $display("FAIL cart_sum: got %0d want %0d", o_cart_sum, m_sum);
    end
`endif
  endtask

  task automatic read_chk(input int slot, input int addr);
    int e;
    @(negedge clk);
    i_rd_slot = 1'(slot);
    i_rd_addr = ADDR_W'(addr);
    @(negedge clk);
    e = m_mem[slot][addr & m_mask[slot]];
    if (e >= 0) begin
      n_cmp++;
      if (o_rd_data !== 8'(e)) begin
        n_bad++;
        $display("FAIL read s%0d a%03h: got %02h want %02h", slot, addr, o_rd_data, e);
      end
    end
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++) begin
      read_chk($urandom_range(0, SLOTS-1), $urandom_range(0, DEPTH-1));
    end
  endtask

  task automatic wait_release(input string tag);
    int got;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_sys_reset === 1'b0) begin
        got = 1;
        break;
      end
    end
    n_cmp++;
    if (got == 0) begin
      n_bad++;
      $display("FAIL %s: sys_reset still %b after 100 cycles, want 0", tag, o_sys_reset);
    end
  endtask

  // Drives one download of the queued bytes; optional wait for IDLE with hold check
  task automatic run_load(input int idx, input bit wait_idle, input bit fall_last);
    int s, sz, hi, a, d;
    bit ok;
    s  = idx - INDEX_BASE;
    ok = (s >= 0) && (s < SLOTS);
    @(negedge clk);
    i_download = 1'b1;
    i_index    = 8'(idx);
    i_wr       = 1'b0;
    if (ok) begin
      m_loaded[s] = 1'b0;
      m_ovf[s]    = 1'b0;
      m_sum       = 0;
    end
    sz = 0;
    foreach (q_addr[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        i_wr = 1'b0;
      end
      @(negedge clk);
      if (!ok) begin
        n_cmp++;
        if (o_sys_reset !== 1'b0) begin
          n_bad++;
          $display("FAIL bad_index_sys_reset: got %b want 0", o_sys_reset);
        end
      end
      a = q_addr[i];
      d = q_data[i];
      i_wr   = 1'b1;
      i_addr = 25'(a);
      i_dout = 8'(d);
      if (fall_last && (i == q_addr.size() - 1)) i_download = 1'b0;
      if (ok) begin
        if (a < DEPTH) begin
          m_mem[s][a] = d;
          if (a + 1 > sz) sz = a + 1;
          m_sum = (m_sum + d) & 16'hFFFF;
        end else begin
          m_ovf[s] = 1'b1;
          sz = DEPTH;
        end
      end
    end
    if (!(fall_last && (q_addr.size() > 0))) begin
      @(negedge clk);
      i_wr       = 1'b0;
      i_download = 1'b0;
    end
    if (ok) begin
      m_size      = sz;
      m_loaded[s] = (sz != 0);
      m_mask[s]   = mask_of(sz);
    end
    if (!wait_idle) return;
    hi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      i_wr       = 1'b0;
      i_download = 1'b0;
      if (o_sys_reset !== 1'b1) break;
      hi++;
      n_cmp++;
      if (o_rd_data !== 8'hFF) begin
        n_bad++;
        $display("FAIL hold_rd_data: got %02h want ff", o_rd_data);
      end
    end
    n_cmp++;
    if (hi != (ok ? RESET_HOLD : 0)) begin
      n_bad++;
      $display("FAIL hold_len idx%0d: got %0d cycles want %0d", idx, hi, ok ? RESET_HOLD : 0);
    end
    check_status();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_sys_reset !== 1'b1) begin n_bad++; $display("FAIL reset_sys_reset: got %b want 1", o_sys_reset); end
    n_cmp++;
    if (o_rd_data !== 8'hFF) begin n_bad++; $display("FAIL reset_rd_data: got %02h want ff", o_rd_data); end
    check_status();
    i_reset = 1'b0;
    wait_release("reset_release");
  endtask

  task automatic test_full_load();
    q_addr = {}; q_data = {};
    for (int a = 0; a < DEPTH; a++) begin q_addr.push_back(a); q_data.push_back(a & 255); end
    run_load(1, 1'b1, 1'b0);
    n_cmp++;
    if (o_cart_loaded !== 2'b01) begin n_bad++; $display("FAIL full_loaded: got %b want 01", o_cart_loaded); end
    n_cmp++;
    if (o_cart_size !== 13'd4096) begin n_bad++; $display("FAIL full_size: got %0d want 4096", o_cart_size); end
    @(negedge clk); i_rd_slot = 1'b0; i_rd_addr = 12'h123;
    @(negedge clk);
    n_cmp++;
    if (o_rd_data !== 8'h23) begin n_bad++; $display("FAIL full_read_123: got %02h want 23", o_rd_data); end
    random_reads(8);
  endtask

  task automatic test_mirror();
    q_addr = {}; q_data = {};
    for (int a = 0; a < 1024; a++) begin q_addr.push_back(a); q_data.push_back($urandom_range(0, 255)); end
    run_load(1, 1'b1, 1'b1);
    @(negedge clk); i_rd_slot = 1'b0; i_rd_addr = 12'h523;
    @(negedge clk);
    n_cmp++;
    if (o_rd_data !== 8'(m_mem[0][12'h123])) begin
      n_bad++;
      $display("FAIL mirror_523: got %02h want %02h", o_rd_data, m_mem[0][12'h123]);
    end
    n_cmp++;
    if (o_cart_size !== 13'd1024) begin n_bad++; $display("FAIL mirror_size: got %0d want 1024", o_cart_size); end
    random_reads(8);
  endtask

  task automatic test_overflow();
    q_addr = {}; q_data = {};
    for (int a = 0; a < 5000; a++) begin q_addr.push_back(a); q_data.push_back($urandom_range(0, 255)); end
    run_load(1, 1'b1, 1'b0);
    n_cmp++;
    if (o_cart_overflow[0] !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", o_cart_overflow[0]); end
    read_chk(0, 0);
    read_chk(0, DEPTH - 1);
    random_reads(8);
  endtask

  task automatic test_bad_index();
    q_addr = {}; q_data = {};
    for (int a = 0; a < 20; a++) begin q_addr.push_back(a); q_data.push_back(8'hA5); end
    run_load(7, 1'b1, 1'b0);
    for (int a = 0; a < 4; a++) read_chk(0, a);
  endtask

  task automatic test_random_loads();
    int lim, n;
    for (int k = 0; k < 8; k++) begin
      q_addr = {}; q_data = {};
      n = $urandom_range(0, 40);
      case ($urandom_range(0, 2))
        0: lim = 15;
        1: lim = 255;
        default: lim = DEPTH - 1;
      endcase
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0) q_addr.push_back(DEPTH + $urandom_range(0, 100000));
        else q_addr.push_back($urandom_range(0, lim));
        q_data.push_back($urandom_range(0, 255));
      end
      run_load($urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
      random_reads(6);
    end
  endtask

  task automatic test_back_to_back();
    q_addr = {}; q_data = {};
    for (int j = 0; j < 300; j++) begin q_addr.push_back($urandom_range(0, 511)); q_data.push_back($urandom_range(0, 255)); end
    run_load(1, 1'b0, 1'b1);
    q_addr = {}; q_data = {};
    for (int j = 0; j < 200; j++) begin q_addr.push_back($urandom_range(0, 2047)); q_data.push_back($urandom_range(0, 255)); end
    run_load(2, 1'b1, 1'b0);
    random_reads(10);
  endtask

  task automatic test_mid_reset();
    int d;
    q_addr = {}; q_data = {};
    for (int j = 0; j < 10; j++) begin q_addr.push_back(j); q_data.push_back($urandom_range(0, 255)); end
    run_load(2, 1'b1, 1'b0);
    @(negedge clk);
    i_download = 1'b1;
    i_index    = 8'd1;
    i_wr       = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      d = $urandom_range(0, 255);
      i_wr = 1'b1; i_addr = 25'(j); i_dout = 8'(d);
      m_mem[0][j] = d;
    end
    @(negedge clk);
    i_wr    = 1'b0;
    i_reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (o_sys_reset !== 1'b1) begin n_bad++; $display("FAIL midreset_sys_reset: got %b want 1", o_sys_reset); end
    check_status();
    i_download = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    wait_release("midreset_release");
    check_status();
    read_chk(0, 0);
    read_chk(0, 199);
    read_chk(1, 5);
    random_reads(6);
  endtask

`ifdef RCA_CART_CHECKSUM_EN
  task automatic test_checksum();
    q_addr = {0, 1, 2};
    q_data = {1, 2, 3};
    run_load(1, 1'b1, 1'b0);
    n_cmp++;
    if (o_cart_sum !== 16'd6) begin n_bad++; $display("FAIL checksum_123: got %0d want 6", o_cart_sum); end
  endtask
`endif

  initial begin
    for (int s = 0; s < SLOTS; s++)
      for (int a = 0; a < DEPTH; a++) m_mem[s][a] = -1;
    model_reset();
    test_reset();
    test_full_load();
    test_mirror();
    test_overflow();
    test_bad_index();
    test_random_loads();
    test_back_to_back();
`ifdef RCA_CART_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
